// File: rtl/branch_predictor.sv
// Direct-mapped table of 2-bit saturating counters with execute-stage training and misprediction tracking.
// Optional gshare indexing (PC XOR global history) is enabled by defining BRANCH_PREDICTOR_GSHARE_EN.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_valid,
  input  logic [31:0]           fetch_pc,
  output logic                  predict_taken,
  output logic [INDEX_BITS-1:0] predict_index,
  input  logic                  resolve_valid,
  input  logic [INDEX_BITS-1:0] resolve_index,
  input  logic                  resolve_predicted,
  input  logic                  resolve_taken,
  output logic                  mispredict,
  output logic [COUNT_BITS-1:0] mispredict_count
);

  localparam int ENTRIES = 2 ** INDEX_BITS;

  logic [1:0]            table_q [ENTRIES];
  logic [INDEX_BITS-1:0] ghr;
  logic                  unused_pc_bits;

  assign unused_pc_bits = ^{fetch_pc[31:INDEX_BITS+2], fetch_pc[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  // History is trained only by resolved branches, so it never needs repair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (resolve_valid) begin
      ghr <= {ghr[INDEX_BITS-2:0], resolve_taken};
    end
  end
`else
  assign ghr = '0;
`endif

  assign predict_index = fetch_pc[INDEX_BITS+1:2] ^ ghr;
  assign predict_taken = fetch_valid & table_q[predict_index][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= 2'b01;
      end
    end else if (resolve_valid) begin
      if (resolve_taken) begin
        if (table_q[resolve_index] != 2'b11) begin
          table_q[resolve_index] <= table_q[resolve_index] + 2'b01;
        end
      end else begin
        if (table_q[resolve_index] != 2'b00) begin
          table_q[resolve_index] <= table_q[resolve_index] - 2'b01;
        end
      end
    end
  end

  // The prediction carried with the branch is trusted; the table is not re-read here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict       <= 1'b0;
      mispredict_count <= '0;
    end else begin
      mispredict <= resolve_valid & (resolve_predicted != resolve_taken);
      if (resolve_valid && (resolve_predicted != resolve_taken) &&
          (mispredict_count != {COUNT_BITS{1'b1}})) begin
        mispredict_count <= mispredict_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized self-checking bench for branch_predictor against a behavioural table model.
module tb_branch_predictor;

  localparam int IB = 6;
  localparam int CB = 4;

  logic          clk;
  logic          rst_n;
  logic          fetch_valid;
  logic [31:0]   fetch_pc;
  logic          predict_taken;
  logic [IB-1:0] predict_index;
  logic          resolve_valid;
  logic [IB-1:0] resolve_index;
  logic          resolve_predicted;
  logic          resolve_taken;
  logic          mispredict;
  logic [CB-1:0] mispredict_count;

  int errors = 0;
  int checks = 0;

  // Reference model: counter strengths 0..3, history and count as plain integers.
  int ctr [64];
  int m_ghr;
  int m_count;
  int m_mis;

  branch_predictor #(.INDEX_BITS(IB), .COUNT_BITS(CB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc),
    .predict_taken(predict_taken),
    .predict_index(predict_index),
    .resolve_valid(resolve_valid),
    .resolve_index(resolve_index),
    .resolve_predicted(resolve_predicted),
    .resolve_taken(resolve_taken),
    .mispredict(mispredict),
    .mispredict_count(mispredict_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 64; i++) ctr[i] = 1;
    m_ghr = 0;
    m_count = 0;
    m_mis = 0;
  endtask

  function automatic int modelIndex(input logic [31:0] pc);
    return ((pc >> 2) & 63) ^ m_ghr;
  endfunction

  // Drives one cycle: lookup checked before the edge, registered outputs checked after it.
  task automatic applyStimulus(input logic fv, input logic [31:0] pc, input logic rv,
                               input int ridx, input logic rpred, input logic rtaken);
    int idx;
    @(negedge clk);
    fetch_valid       = fv;
    fetch_pc          = pc;
    resolve_valid     = rv;
    resolve_index     = IB'(ridx);
    resolve_predicted = rpred;
    resolve_taken     = rtaken;
    #1;
    idx = modelIndex(pc);
    checkOutput("predict_index", int'(predict_index), idx);
    checkOutput("predict_taken", int'(predict_taken), fv ? (ctr[idx] >= 2 ? 1 : 0) : 0);
    @(posedge clk);
    if (rv) begin
      if (rtaken) ctr[ridx] = (ctr[ridx] == 3) ? 3 : ctr[ridx] + 1;
      else        ctr[ridx] = (ctr[ridx] == 0) ? 0 : ctr[ridx] - 1;
      m_mis = (rpred != rtaken) ? 1 : 0;
      if (m_mis == 1 && m_count < (1 << CB) - 1) m_count++;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
      m_ghr = ((m_ghr << 1) | int'(rtaken)) & 63;
`endif
    end else begin
      m_mis = 0;
    end
    #1;
    checkOutput("mispredict", int'(mispredict), m_mis);
    checkOutput("mispredict_count", int'(mispredict_count), m_count);
  endtask

  task automatic checkAllZero(input string tag);
    for (int i = 0; i < 64; i++) begin
      fetch_valid = 1'b1;
      fetch_pc = 32'(i * 4);
      #0.1;
      checkOutput(tag, int'(predict_taken), 0);
    end
  endtask

  initial begin
    logic [31:0] pc;
    int ridx;
    fetch_valid = 0; fetch_pc = 0; resolve_valid = 0; resolve_index = 0;
    resolve_predicted = 0; resolve_taken = 0;
    rst_n = 1'b1;
    modelReset();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_mispredict", int'(mispredict), 0);
    checkOutput("reset_count", int'(mispredict_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh-table lookups at the low and high ends of the index range.
    applyStimulus(1, 32'h00, 0, 0, 0, 0);
    applyStimulus(1, 32'h04, 0, 0, 0, 0);
    applyStimulus(1, 32'hFC, 0, 0, 0, 0);
    checkOutput("index_of_fc", int'(predict_index), 63);

    // Train index 5 up to saturation and back down.
    applyStimulus(1, 32'h14, 1, 5, 0, 1);
    applyStimulus(1, 32'h14, 1, 5, 1, 1);
    applyStimulus(1, 32'h14, 1, 5, 1, 1);
    applyStimulus(1, 32'h14, 1, 5, 1, 0);
    applyStimulus(1, 32'h14, 1, 5, 1, 0);
    applyStimulus(1, 32'h14, 0, 0, 0, 0);

    // Same-cycle lookup and update of index 7, then the follow-up lookup.
    applyStimulus(1, 32'h1C, 1, 7, 0, 1);
    applyStimulus(1, 32'h1C, 1, 7, 0, 1);
    applyStimulus(1, 32'h1C, 0, 0, 0, 0);
    applyStimulus(0, 32'h1C, 0, 0, 0, 0);

    // Drive the misprediction count past saturation.
    for (int i = 0; i < (1 << CB) + 3; i++) applyStimulus(0, 32'h0, 1, 9, 1, 0);
    checkOutput("count_saturated", int'(mispredict_count), 15);

    // Mid-cycle reset with an update pending: everything clears and the update is dropped.
    @(negedge clk);
    resolve_valid = 1; resolve_index = 3; resolve_predicted = 0; resolve_taken = 1;
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("midreset_mispredict", int'(mispredict), 0);
    checkOutput("midreset_count", int'(mispredict_count), 0);
    checkAllZero("midreset_predict");
    @(posedge clk);
    @(negedge clk);
    resolve_valid = 0;
    rst_n = 1'b1;
    applyStimulus(1, 32'h0C, 0, 0, 0, 0);

    // Three taken resolves at index 0; with gshare the next 0x1C lookup folds to index 0.
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 1, 0, 1, 1);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    applyStimulus(1, 32'h1C, 0, 0, 0, 0);
    checkOutput("gshare_index", int'(predict_index), 0);
`else
    applyStimulus(1, 32'h1C, 0, 0, 0, 0);
    checkOutput("plain_index", int'(predict_index), 7);
`endif

    // Random traffic concentrated on a few indices so counters saturate both ways.
    for (int n = 0; n < 400; n++) begin
      pc = $urandom;
      if ($urandom_range(0, 1) == 1) pc[7:2] = 6'($urandom_range(0, 7));
      ridx = $urandom_range(0, 7);
      applyStimulus(1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 3) != 0),
                    ridx, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the pipelined RISC-V core. It holds a direct-mapped table of 2-bit saturating counters indexed by the fetch PC and gives fetch a taken/not-taken guess. It is trained at the execute stage by the resolved outcome from the branch comparator. It also flags mispredictions and keeps a saturating misprediction count for tracing and performance runs.

## Interface
- `INDEX_BITS`, default 6: log2 of the number of table entries (64 entries by default).
- `COUNT_BITS`, default 16: width of the misprediction counter.

- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `fetch_valid`  in  1: fetch is looking up a branch this cycle.
- `fetch_pc`  in  32 (`Word`): PC of the instruction being fetched.
- `predict_taken`  out  1: prediction for `fetch_pc`. Combinational. 0 when `fetch_valid`=0.
- `predict_index`  out  INDEX_BITS: table index used for this lookup. Carried down the pipeline with the instruction.
- `resolve_valid`  in  1: a conditional branch resolves in execute this cycle.
- `resolve_index`  in  INDEX_BITS: the `predict_index` that was captured for this branch at fetch.
- `resolve_predicted`  in  1: the prediction that was made for this branch at fetch.
- `resolve_taken`  in  1: actual outcome, taken from the comparator `out`.
- `mispredict`  out  1: registered. High for one cycle after a resolve where predicted ≠ taken.
- `mispredict_count`  out  COUNT_BITS: saturating count of mispredictions.

## Operation
- Table: 2^INDEX_BITS counters, 2 bits each.
  - Encoding: 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
  - Prediction is counter bit 1.
- Index, without the configuration macro: `fetch_pc[INDEX_BITS+1:2]`. PC bits [1:0] are ignored because instructions are word-aligned.
- Update, when `resolve_valid`=1 at a rising edge:
  - If `resolve_taken`=1: counter[`resolve_index`] increments, saturating at 11.
  - If `resolve_taken`=0: the counter decrements, saturating at 00.
- Misprediction, when `resolve_valid`=1 at a rising edge:
  - `mispredict` ← (`resolve_predicted` ≠ `resolve_taken`).
  - If that comparison is true, `mispredict_count` increments, saturating at all-ones with no wrap.
  - When `resolve_valid`=0, `mispredict` ← 0.
- The block trusts `resolve_predicted`. It does not re-read the table to recompute what was predicted.
- Reset values (asynchronous, applied immediately when `rst_n` falls):
  - All counters = 01 (weakly-not-taken).
  - `mispredict` = 0, `mispredict_count` = 0, global history = 0.
  - `predict_taken` therefore reads 0 for every PC while reset is held and afterwards until training.
- Reset asserted mid-operation discards any pending update. It is not applied on release.

## Timing
- Lookup has zero latency: `predict_taken` and `predict_index` are combinational from `fetch_pc`, the table, and the history.
- Update latency is one cycle. The counter written at edge N is visible to lookups from cycle N+1 onward.
- Same-cycle read and write to one index: the lookup returns the pre-update value. There is no bypass.
- `mispredict` is valid in the cycle after the resolving edge and lasts exactly one cycle per mispredicted resolve.
- Back-to-back resolves to the same index on consecutive cycles each apply, in order. Updates are never lost.
- No handshake or back-pressure: one lookup and one resolve are accepted every cycle.

## Configuration
- Macro: `BRANCH_PREDICTOR_GSHARE_EN`.
- When defined, the block keeps an INDEX_BITS global history register, GHR.
  - Index = `fetch_pc[INDEX_BITS+1:2]` XOR GHR.
  - GHR is non-speculative: on each `resolve_valid` edge, GHR ← {GHR[INDEX_BITS-2:0], `resolve_taken`}.
  - Because `resolve_index` is carried with the instruction, GHR changes between fetch and resolve do not affect which counter is trained.
- When undefined, there is no GHR and the index is the PC bits alone. Lookup behaviour must match a GHR that stays 0 forever.

## Test plan
- Reset, then lookups at PCs 0x00, 0x04 and 0xFC → `predict_taken`=0 and `predict_index` = 0, 1, 63; `mispredict_count`=0.
- Two taken resolves at index 5 → predict for PC 0x14 goes 0, then 1 after the first resolve. A third taken resolve holds the counter at 11. Two not-taken resolves then bring it to 01 and the prediction back to 0.
- Resolve with predicted=0, taken=1 → `mispredict`=1 for exactly one cycle after the edge; count goes 0→1. A resolve with predicted=1, taken=1 → `mispredict`=0 and the count is unchanged.
- Resolve to index 7 in the same cycle as a lookup of PC 0x1C → the lookup shows the old counter; the next cycle shows the updated value.
- Preload `mispredict_count` near all-ones via 2^COUNT_BITS+3 mispredicts (COUNT_BITS overridden to 4) → the count holds at 15. Then drop `rst_n` mid-cycle → all outputs clear immediately and every prediction reads 0.
- `BRANCH_PREDICTOR_GSHARE_EN` defined: resolve taken three times at index 0 → GHR=0b000111. A lookup at PC 0x1C then gives index 7 XOR 7 = 0.
